// File: rtl/step_dir_gen.sv
// Multi-channel step/dir/enable pulse generator with per-channel position tracking.
// Optional limit-switch gating is built when STEP_DIR_GEN_LIMIT_EN is defined.

module step_dir_ch #(
  parameter int POS_W     = 32,
  parameter int PER_W     = 16,
  parameter int STEP_HI   = 8,
  parameter int DIR_SETUP = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_tgt,
  input  logic             wr_per,
  input  logic             wr_ctrl,
  input  logic             wr_pos,
  input  logic [POS_W-1:0] wr_data,
  input  logic             blk_p,
  input  logic             blk_n,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             enn,
  output logic             busy
);
  localparam int SH_W  = $clog2(2*STEP_HI + DIR_SETUP + 1);
  localparam int CNT_W = ((PER_W > SH_W) ? PER_W : SH_W) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, per_x, two_hi, lo_load;
  logic [POS_W-1:0] tgt, d;
  logic [PER_W-1:0] per;
  logic             en, dir_nx, want, go, first;

  assign d     = tgt - pos;
  assign want  = ~d[POS_W-1];
  // a step toward an asserted limit is treated exactly like d==0
  assign go    = en && (d != '0) && !(want ? blk_p : blk_n);
  assign busy  = (state != IDLE) || go;
  assign first = (state == HIGH) && (cnt == CNT_W'(STEP_HI-1));

  assign per_x   = CNT_W'(per);
  assign two_hi  = CNT_W'(2*STEP_HI);
  assign lo_load = ((per_x > two_hi) ? per_x : two_hi) - CNT_W'(STEP_HI+1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir;
    case (state)
      IDLE: if (go) begin
        if (want != dir) begin
          dir_nx   = want;
          state_nx = SETUP;
          cnt_nx   = CNT_W'(DIR_SETUP-1);
        end else begin
          state_nx = HIGH;
          cnt_nx   = CNT_W'(STEP_HI-1);
        end
      end
      SETUP: if (cnt == '0) begin
        state_nx = HIGH;
        cnt_nx   = CNT_W'(STEP_HI-1);
      end else cnt_nx = cnt - 1'b1;
      HIGH: if (cnt == '0) begin
        state_nx = LOW;
        cnt_nx   = lo_load;
      end else cnt_nx = cnt - 1'b1;
      LOW: if (cnt == '0) begin
        if (go && (want == dir)) begin
          state_nx = HIGH;
          cnt_nx   = CNT_W'(STEP_HI-1);
        end else state_nx = IDLE;
      end else cnt_nx = cnt - 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      enn   <= 1'b1;
      en    <= 1'b0;
      tgt   <= '0;
      per   <= '0;
      pos   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dir   <= dir_nx;
      step  <= (state_nx == HIGH);
      enn   <= ~en;
      if (wr_tgt)  tgt <= wr_data;
      if (wr_per)  per <= wr_data[PER_W-1:0];
      if (wr_ctrl) en  <= wr_data[0];
      // position moves at the end of the first HIGH cycle, so it never meets an IDLE-only preset
      if (wr_pos && state == IDLE) pos <= wr_data;
      else if (first)              pos <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
    end
  end
endmodule

module step_dir_gen #(
  parameter int CHANNELS  = 4,
  parameter int CH_W      = 2,
  parameter int POS_W     = 32,
  parameter int PER_W     = 16,
  parameter int STEP_HI   = 8,
  parameter int DIR_SETUP = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_sel,
  input  logic [POS_W-1:0]    wr_data,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [POS_W-1:0]    rd_data,
  output logic [CHANNELS-1:0] step,
  output logic [CHANNELS-1:0] dir,
  output logic [CHANNELS-1:0] enn,
  output logic [CHANNELS-1:0] busy
`ifdef STEP_DIR_GEN_LIMIT_EN
  ,
  input  logic [CHANNELS-1:0] lim_p,
  input  logic [CHANNELS-1:0] lim_n
`endif
);
  logic [CHANNELS-1:0]            hit, lp_s, ln_s;
  logic [CHANNELS-1:0][POS_W-1:0] pos_all;
  logic [POS_W-1:0]               rd_mux;

`ifdef STEP_DIR_GEN_LIMIT_EN
  logic [1:0][CHANNELS-1:0] lp_ff, ln_ff;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lp_ff <= '0;
      ln_ff <= '0;
    end else begin
      lp_ff <= {lp_ff[0], lim_p};
      ln_ff <= {ln_ff[0], lim_n};
    end
  end
  assign lp_s = lp_ff[1];
  assign ln_s = ln_ff[1];
`else
  assign lp_s = '0;
  assign ln_s = '0;
`endif

  // out-of-range channel indices match no lane, so such writes fall away
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign hit[i] = wr_en && (wr_ch == CH_W'(i));
    step_dir_ch #(
      .POS_W(POS_W), .PER_W(PER_W), .STEP_HI(STEP_HI), .DIR_SETUP(DIR_SETUP)
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .wr_tgt  (hit[i] && wr_sel == 2'd0),
      .wr_per  (hit[i] && wr_sel == 2'd1),
      .wr_ctrl (hit[i] && wr_sel == 2'd2),
      .wr_pos  (hit[i] && wr_sel == 2'd3),
      .wr_data (wr_data),
      .blk_p   (lp_s[i]),
      .blk_n   (ln_s[i]),
      .pos     (pos_all[i]),
      .step    (step[i]),
      .dir     (dir[i]),
      .enn     (enn[i]),
      .busy    (busy[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (rd_ch == CH_W'(i)) rd_mux = pos_all[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_data <= '0;
    else         rd_data <= rd_mux;
  end
endmodule

// File: tb/tb_step_dir_gen.sv
// Bench for step_dir_gen: scenario tasks plus randomized moves against an event-level model
// (pulse count, width, spacing, dir setup, final position).

module tb_step_dir_gen;
  localparam int CH = 4, CHW = 3, PW = 32, PERW = 16, SHI = 8, DS = 4;

  logic            clk = 0, resetn = 1, wr_en = 0;
  logic [CHW-1:0]  wr_ch = '0, rd_ch = '0;
  logic [1:0]      wr_sel = '0;
  logic [PW-1:0]   wr_data = '0;
  logic [PW-1:0]   rd_data;
  logic [CH-1:0]   step, dir, enn, busy;
`ifdef STEP_DIR_GEN_LIMIT_EN
  logic [CH-1:0]   lim_p = '0, lim_n = '0;
`endif

  step_dir_gen #(.CHANNELS(CH), .CH_W(CHW), .POS_W(PW), .PER_W(PERW), .STEP_HI(SHI), .DIR_SETUP(DS)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_ch(rd_ch), .rd_data(rd_data), .step(step), .dir(dir), .enn(enn), .busy(busy)
`ifdef STEP_DIR_GEN_LIMIT_EN
    , .lim_p(lim_p), .lim_n(lim_n)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [PW-1:0] mpos [CH];
  logic          mdir [CH];

  // pin monitor: owns all counters; tasks only write seg/exp_gap
  int cyc = 0;
  int rises [CH]    = '{default:0};
  int bad_w [CH]    = '{default:0};
  int setup_v [CH]  = '{default:0};
  int gap_bad [CH]  = '{default:0};
  int rise_t [CH]   = '{default:0};
  int dir_t [CH]    = '{default:-100};
  int rise_seg [CH] = '{default:-1};
  int seg [CH]      = '{default:0};
  int exp_gap [CH]  = '{default:16};
  logic [CH-1:0] step_q = '0, dir_q = '0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < CH; i++) begin
      if (dir[i] !== dir_q[i]) begin
        dir_t[i] = cyc;
        if (step[i] || step_q[i]) setup_v[i]++;
      end
      if (step[i] && !step_q[i]) begin
        if (rises[i] > 0 && rise_seg[i] == seg[i] && cyc - rise_t[i] != exp_gap[i]) gap_bad[i]++;
        if (cyc - dir_t[i] < DS) setup_v[i]++;
        rises[i]++;
        rise_t[i] = cyc;
        rise_seg[i] = seg[i];
      end
      if (!step[i] && step_q[i] && cyc - rise_t[i] != SHI) bad_w[i]++;
    end
    step_q = step;
    dir_q  = dir;
  end

  int b_r, b_w, b_s, b_g;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wr(input int ch, input int sel, input logic [PW-1:0] data);
    wr_en = 1; wr_ch = CHW'(ch); wr_sel = 2'(sel); wr_data = data;
    tick();
    wr_en = 0;
  endtask

  task automatic rdpos(input int ch, output logic [PW-1:0] v);
    rd_ch = CHW'(ch);
    tick();
    v = rd_data;
  endtask

  task automatic snap(input int ch);
    b_r = rises[ch]; b_w = bad_w[ch]; b_s = setup_v[ch]; b_g = gap_bad[ch];
  endtask

  task automatic start_move(input int ch, input int per, input logic [PW-1:0] tgt);
    wr(ch, 1, PW'(per));
    exp_gap[ch] = (per > 2*SHI) ? per : 2*SHI;
    seg[ch]++;
    snap(ch);
    wr(ch, 0, tgt);
  endtask

  task automatic wait_idle(input int ch, input int budget);
    int n = 0;
    while (busy[ch] && n < budget) begin tick(); n++; end
    nvec++;
    if (busy[ch] !== 1'b0) begin nerr++; $display("FAIL idle_timeout ch%0d busy=%b want 0", ch, busy[ch]); end
  endtask

  task automatic wait_rises(input int ch, input int k);
    int n = 0;
    while (rises[ch] - b_r < k && n < 3000) begin tick(); n++; end
    nvec++;
    if (rises[ch] - b_r < k) begin nerr++; $display("FAIL rise_timeout ch%0d rises=%0d want %0d", ch, rises[ch]-b_r, k); end
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
    tick();
    for (int i = 0; i < CH; i++) begin mpos[i] = '0; mdir[i] = 1'b0; end
    nvec++; if (step !== '0)    begin nerr++; $display("FAIL rst_step got %b want 0", step); end
    nvec++; if (dir !== '0)     begin nerr++; $display("FAIL rst_dir got %b want 0", dir); end
    nvec++; if (enn !== '1)     begin nerr++; $display("FAIL rst_enn got %b want 1111", enn); end
    nvec++; if (busy !== '0)    begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
    nvec++; if (rd_data !== '0) begin nerr++; $display("FAIL rst_rd got %h want 0", rd_data); end
  endtask

  task automatic check_move(input string nm, input int ch, input int exp_r);
    logic [PW-1:0] p;
    rdpos(ch, p);
    nvec++; if (rises[ch]-b_r !== exp_r) begin nerr++; $display("FAIL %s_rises got %0d want %0d", nm, rises[ch]-b_r, exp_r); end
    nvec++; if (bad_w[ch]-b_w + setup_v[ch]-b_s + gap_bad[ch]-b_g !== 0) begin
      nerr++; $display("FAIL %s_timing width_err=%0d setup_err=%0d gap_err=%0d want 0", nm, bad_w[ch]-b_w, setup_v[ch]-b_s, gap_bad[ch]-b_g);
    end
    nvec++; if (p !== mpos[ch]) begin nerr++; $display("FAIL %s_pos got %h want %h", nm, p, mpos[ch]); end
    nvec++; if (dir[ch] !== mdir[ch]) begin nerr++; $display("FAIL %s_dir got %b want %b", nm, dir[ch], mdir[ch]); end
  endtask

  task automatic test_basic();
    wr(0, 2, 1);
    start_move(0, 20, 5);
    wait_idle(0, 1000);
    mpos[0] = 5; mdir[0] = 1;
    check_move("basic", 0, 5);
    nvec++; if (enn[0] !== 1'b0) begin nerr++; $display("FAIL basic_enn got %b want 0", enn[0]); end
  endtask

  task automatic test_clamp();
    start_move(0, 3, 9);
    wait_idle(0, 1000);
    mpos[0] = 9;
    check_move("clamp", 0, 4);
  endtask

  task automatic test_reversal();
    wr(1, 2, 1);
    start_move(1, 20, 100);
    wait_rises(1, 10);
    seg[1]++;
    wr(1, 0, 32'hFFFF_FFFE);
    wait_idle(1, 3000);
    mpos[1] = 32'hFFFF_FFFE; mdir[1] = 0;
    check_move("reversal", 1, 22);
  endtask

  task automatic test_en_clear();
    logic [PW-1:0] p;
    wr(2, 2, 1);
    start_move(2, 30, 50);
    wait_rises(2, 3);
    wr(2, 2, 0);
    tick();
    nvec++; if (enn[2] !== 1'b1) begin nerr++; $display("FAIL enclr_enn got %b want 1", enn[2]); end
    nvec++; if (busy[2] !== 1'b1) begin nerr++; $display("FAIL enclr_busy got %b want 1", busy[2]); end
    wr(2, 3, 1234);
    wait_idle(2, 500);
    mpos[2] = 3; mdir[2] = 1;
    check_move("enclr", 2, 3);
    wr(2, 3, 32'h7FFF_FFFF);
    rdpos(2, p);
    nvec++; if (p !== 32'h7FFF_FFFF) begin nerr++; $display("FAIL preset_pos got %h want 7fffffff", p); end
    start_move(2, 0, 32'h8000_0000);
    wr(2, 2, 1);
    wait_idle(2, 500);
    mpos[2] = 32'h8000_0000;
    check_move("wrap", 2, 1);
  endtask

  task automatic test_bad_ch();
    logic [PW-1:0] p;
    wr(5, 0, 77);
    wr(6, 3, 99);
    wr(7, 2, 0);
    wr(5, 2, 1);
    repeat (3) tick();
    nvec++; if (busy !== '0) begin nerr++; $display("FAIL badch_busy got %b want 0", busy); end
    nvec++; if (enn !== 4'b1000) begin nerr++; $display("FAIL badch_enn got %b want 1000", enn); end
    for (int i = 0; i < CH; i++) begin
      rdpos(i, p);
      nvec++; if (p !== mpos[i]) begin nerr++; $display("FAIL badch_pos%0d got %h want %h", i, p, mpos[i]); end
    end
    rdpos(1, p);
    rd_ch = 0;
    #2;
    nvec++; if (rd_data !== mpos[1]) begin nerr++; $display("FAIL rd_latency got %h want %h", rd_data, mpos[1]); end
    tick();
    nvec++; if (rd_data !== mpos[0]) begin nerr++; $display("FAIL rd_ch0 got %h want %h", rd_data, mpos[0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < CH; i++) wr(i, 2, 1);
    for (int k = 0; k < 12; k++) begin
      int ch, per, delta;
      ch    = int'($urandom_range(0, CH-1));
      per   = int'($urandom_range(0, 40));
      delta = int'($urandom_range(0, 12)) - 6;
      start_move(ch, per, mpos[ch] + PW'(delta));
      wait_idle(ch, 2000);
      mpos[ch] = mpos[ch] + PW'(delta);
      if (delta != 0) mdir[ch] = (delta > 0);
      check_move("rand", ch, (delta < 0) ? -delta : delta);
    end
  endtask

`ifdef STEP_DIR_GEN_LIMIT_EN
  task automatic test_limit();
    lim_p[3] = 1'b1;
    repeat (3) tick();
    wr(3, 2, 1);
    start_move(3, 20, mpos[3] + 10);
    repeat (4) tick();
    nvec++; if (busy[3] !== 1'b0) begin nerr++; $display("FAIL lim_busy got %b want 0", busy[3]); end
    nvec++; if (rises[3]-b_r !== 0) begin nerr++; $display("FAIL lim_steps got %0d want 0", rises[3]-b_r); end
    start_move(3, 20, mpos[3] - 3);
    wait_idle(3, 1000);
    mpos[3] = mpos[3] - 3; mdir[3] = 0;
    check_move("lim_away", 3, 3);
    lim_p[3] = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [PW-1:0] p;
    start_move(0, 20, mpos[0] + 5);
    wait_rises(0, 2);
    resetn = 0;
    #1;
    nvec++; if (step !== '0) begin nerr++; $display("FAIL rstmid_step got %b want 0", step); end
    nvec++; if (enn !== '1 || busy !== '0) begin nerr++; $display("FAIL rstmid_enn_busy got %b/%b want 1111/0000", enn, busy); end
    #1;
    resetn = 1;
    tick();
    rdpos(0, p);
    nvec++; if (p !== '0) begin nerr++; $display("FAIL rstmid_pos got %h want 0", p); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_clamp();
    test_reversal();
    test_en_clear();
    test_bad_ch();
    test_random();
`ifdef STEP_DIR_GEN_LIMIT_EN
    test_limit();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
- Parametrised multi-channel step/dir/enable pulse generator. Next generation of the fixed 4-axis step/dir/enn outputs of the TMC5130 controller top level.
- Each channel holds a signed position, a target and a step period. It emits timing-correct step pulses, with dir setup time, until position equals target.
- Sits between the SPI-slave register decoder (write port) and the driver pins. The position readback port feeds the host status frame.

Parameters:
- CHANNELS, 4, number of independent axes (1..16).
- CH_W, 2, width of channel index; CH_W >= clog2(CHANNELS).
- POS_W, 32, width of position/target (two's complement).
- PER_W, 16, width of step period register, in clk cycles.
- STEP_HI, 8, step high time in clk cycles (>=1).
- DIR_SETUP, 4, dir-stable cycles before a step rising edge after a dir change (>=1).

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, active-low
- wr_en  in  1  single-cycle register write strobe
- wr_ch  in  CH_W  target channel of write
- wr_sel  in  2  0=target, 1=period, 2=ctrl (bit0=enable), 3=position preset
- wr_data  in  POS_W  write data (period uses [PER_W-1:0])
- rd_ch  in  CH_W  channel whose position is read
- rd_data  out  POS_W  position of rd_ch, registered
- step  out  CHANNELS  step pulses
- dir  out  CHANNELS  direction, 1=positive
- enn  out  CHANNELS  driver enable, active-low
- busy  out  CHANNELS  channel moving or motion pending

Behaviour:
- Reset is asynchronous, active-low. Reset values: step=0, dir=0, enn=all 1, busy=0, rd_data=0. Per-channel pos=0, target=0, period=0, en=0. All FSMs in IDLE.
- Writes with wr_ch >= CHANNELS are ignored. A write takes effect on the clock edge where wr_en=1.
- enn[i] = ~en[i], registered, 1 cycle after the ctrl write.
- Effective period eff = max(period, 2*STEP_HI).
- Signed difference d = target - pos (mod 2^POS_W); the sign of d selects the direction. Position arithmetic wraps modulo 2^POS_W.
- Per-channel FSM:
  - IDLE: if en && d!=0:
    - want = (d>0).
    - If want != dir: dir<=want, go SETUP.
    - Otherwise go HIGH.
  - SETUP: hold DIR_SETUP cycles, then HIGH.
  - HIGH:
    - step=1 for exactly STEP_HI cycles.
    - pos is incremented or decremented (per dir) on the entry cycle.
    - Then go LOW.
  - LOW: step=0 for eff-STEP_HI cycles. Then:
    - If en && d!=0 && sign(d) matches dir: go directly HIGH.
    - Otherwise go IDLE.
- Result: rising-edge spacing is exactly eff cycles while moving continuously in one direction.
- busy[i] = (state!=IDLE) || (en && d!=0).
- Target write mid-move: sampled at the next LOW->decision. A reversal passes through IDLE and SETUP, so dir never changes while step=1 or within DIR_SETUP cycles of a rising edge.
- Period write mid-move: takes effect on the next LOW phase entry.
- en cleared mid-move: the current HIGH/LOW phase completes, so no truncated pulse. The FSM then goes IDLE. enn deasserts 1 cycle after the write.
- Position preset: accepted only when the channel FSM is IDLE; otherwise ignored.
- Simultaneous preset and internal step: cannot occur, because a preset is only accepted in IDLE.
- rd_data <= pos[rd_ch] each cycle (1-cycle latency). It reflects a same-cycle step update on the following cycle.
- Reset mid-pulse: step drops immediately (async).

Optional Feature:
- Macro: STEP_DIR_GEN_LIMIT_EN.
- When defined, two additional input ports exist:
  - lim_p  in  CHANNELS  positive limit switch, active-high, synchronised internally by a 2-flop chain.
  - lim_n  in  CHANNELS  negative limit switch, same treatment.
- With the macro:
  - A step toward an asserted limit is not started. The IDLE/LOW decision treats it as d==0 for that direction, so busy deasserts once the FSM reaches IDLE.
  - Motion away from the limit is unaffected.
  - A limit asserting during HIGH/LOW lets the current pulse complete.
- Without the macro: ports absent, no limit gating.

Test Plan:
- Reset, en=1 ch0, period=20, target=5 -> 5 step pulses on step[0], each 8 cycles high, rising edges 20 cycles apart. dir[0]=1 for DIR_SETUP(4) cycles before the first edge. Final pos=5, then busy[0]=0.
- Period=3 (below 2*STEP_HI) -> rising-edge spacing clamps to 16 cycles.
- Ch1 moving to +100; at pos 10 write target=-2 -> current pulse completes, dir[1] falls, >=4 cycles before the next edge. pos counts down to 0xFFFFFFFE, i.e. -2.
- Clear en on ch2 during a HIGH phase -> full 8-cycle pulse completes, no further steps, enn[2]=1 one cycle after the write. Preset write while busy is ignored; after IDLE, preset 0x7FFFFFFF and target 0x80000000 -> one step up, pos wraps to 0x80000000.
- Write to wr_ch=5 with CHANNELS=4 -> no state change. rd_ch=0 returns pos one cycle later.
- With STEP_DIR_GEN_LIMIT_EN: lim_p[3]=1, target +10 -> no steps, busy[3]=0. Target -3 -> 3 steps with dir[3]=0.
